uart_tx_fifo: RTL and testbench

Byte buffer that sits directly upstream of the UART transmitter. It decouples the host write interface from the serial line. The host pushes bytes at clock rate. The transmitter drains them one at a time through a valid/ready handshake, only when it is ready to start a new frame. The block provides first-word-fall-through output, full/empty/level status, overflow detection and a synchronous flush.

---
 rtl/uart_pkg.sv | 9 +
 rtl/uart_tx_fifo.sv | 92 +++++++++
 tb/tb_uart_tx_fifo.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: character width and the byte type used by
// the transmitter, the receiver and the transmit FIFO.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte FIFO feeding the UART transmitter, with
// level/full/empty status, sticky overflow flag and synchronous flush.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = UART_DATA_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     full,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    logic [AW:0] wr_ptr_next;
    logic [AW:0] rd_ptr_next;
    logic        overflow_reg;
    logic        overflow_next;

    logic        push_ok;
    logic        pop_ok;
    logic        push_rejected;

    // Extra MSB on each pointer distinguishes full from empty when the
    // index bits coincide.
    assign empty    = (wr_ptr_reg == rd_ptr_reg);
    assign full     = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                      (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
    assign count    = wr_ptr_reg - rd_ptr_reg;
    assign rd_valid = !empty;
    assign overflow = overflow_reg;
    assign rd_data  = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

    assign push_ok       = wr_en && !full;
    assign push_rejected = wr_en && full;
    assign pop_ok        = rd_valid && rd_ready;

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        overflow_next = overflow_reg;
        if (flush) begin
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
            overflow_next = 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_next = wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_next = rd_ptr_reg + 1'b1;
            end
            if (push_rejected) begin
                overflow_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            overflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            overflow_reg <= overflow_next;
        end
    end

    // Storage carries no reset; stale contents are hidden by the empty mask.
    always_ff @(posedge clk) begin
        if (!flush && push_ok) begin
            mem[wr_ptr_reg[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: fill/drain, overflow, push+pop,
// wrap-around, flush and asynchronous reset during a drain.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic       wr_en;
    uart_byte_t wr_data;
    logic       full;
    logic       rd_valid;
    logic       rd_ready;
    uart_byte_t rd_data;
    logic       empty;
    logic [3:0] count;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    uart_byte_t q[$];

    always #5 clk = ~clk;

    uart_tx_fifo #(.DEPTH(8), .WIDTH(UART_DATA_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; applies one cycle of inputs and returns at
    // the next falling edge with the inputs idle again.
    task automatic step(input logic we, input uart_byte_t d, input logic rr, input logic fl);
        wr_en    = we;
        wr_data  = d;
        rd_ready = rr;
        flush    = fl;
        @(posedge clk);
        @(negedge clk);
        wr_en    = 1'b0;
        rd_ready = 1'b0;
        flush    = 1'b0;
        $display("txn wr=%0b data=%02h rd=%0b flush=%0b -> count=%0d head=%02h ovf=%0b",
                 we, d, rr, fl, count, rd_data, overflow);
    endtask

    initial begin
        reset    = 1'b0;
        flush    = 1'b0;
        wr_en    = 1'b0;
        rd_ready = 1'b0;
        wr_data  = '0;

        repeat (3) @(negedge clk);
        check("rst_empty",    32'(empty),    32'd1);
        check("rst_full",     32'(full),     32'd0);
        check("rst_count",    32'(count),    32'd0);
        check("rst_valid",    32'(rd_valid), 32'd0);
        check("rst_data",     32'(rd_data),  32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("rel_empty", 32'(empty), 32'd1);
        check("rel_count", 32'(count), 32'd0);

        // Fill A1..A8 with the transmitter idle.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 8'(8'hA1 + i), 1'b0, 1'b0);
            check("fill_count", 32'(count), 32'(i + 1));
        end
        check("fill_full",  32'(full),     32'd1);
        check("fill_valid", 32'(rd_valid), 32'd1);
        check("fill_head",  32'(rd_data),  32'hA1);

        // Push while full is dropped and raises overflow.
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        check("ovf_flag",  32'(overflow), 32'd1);
        check("ovf_count", 32'(count),    32'd8);
        check("ovf_head",  32'(rd_data),  32'hA1);

        // Rejected push alongside a pop: only the pop takes effect.
        step(1'b1, 8'hFF, 1'b1, 1'b0);
        check("ovfpop_count", 32'(count),    32'd7);
        check("ovfpop_full",  32'(full),     32'd0);
        check("ovfpop_flag",  32'(overflow), 32'd1);
        for (int i = 1; i < 8; i++) begin
            check("drain_data", 32'(rd_data), 32'(8'hA1 + i));
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        check("drain_empty", 32'(empty),    32'd1);
        check("drain_valid", 32'(rd_valid), 32'd0);
        check("drain_data0", 32'(rd_data),  32'd0);
        check("drain_count", 32'(count),    32'd0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("idle_pop_count", 32'(count), 32'd0);

        // Flush at level 5 with overflow still set; its push and pop are lost.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hB1 + i), 1'b0, 1'b0);
        check("pre_flush_count", 32'(count),    32'd5);
        check("pre_flush_ovf",   32'(overflow), 32'd1);
        step(1'b1, 8'hEE, 1'b1, 1'b1);
        check("flush_count", 32'(count),    32'd0);
        check("flush_empty", 32'(empty),    32'd1);
        check("flush_ovf",   32'(overflow), 32'd0);
        check("flush_data",  32'(rd_data),  32'd0);

        // Simultaneous push and pop at level 3.
        step(1'b1, 8'h11, 1'b0, 1'b0);
        check("post_flush_head", 32'(rd_data), 32'h11);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0);
        check("sim_pre_count", 32'(count),   32'd3);
        check("sim_pre_head",  32'(rd_data), 32'h11);
        step(1'b1, 8'h55, 1'b1, 1'b0);
        check("sim_count", 32'(count), 32'd3);
        check("sim_head0", 32'(rd_data), 32'h22);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("sim_head1", 32'(rd_data), 32'h33);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("sim_head2", 32'(rd_data), 32'h55);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("sim_empty", 32'(empty), 32'd1);

        // Wrap-around with the level kept between 2 and 3.
        step(1'b1, 8'hC0, 1'b0, 1'b0);
        q.push_back(8'hC0);
        step(1'b1, 8'hC1, 1'b0, 1'b0);
        q.push_back(8'hC1);
        for (int i = 0; i < 20; i++) begin
            logic we;
            logic rr;
            uart_byte_t d;
            we = ((i % 4) != 2);
            rr = ((i % 4) != 1);
            d  = 8'(8'h40 + i);
            check("wrap_head", 32'(rd_data), 32'(q[0]));
            step(we, d, rr, 1'b0);
            if (rr) void'(q.pop_front());
            if (we) q.push_back(d);
            check("wrap_count", 32'(count), 32'(q.size()));
        end
        while (q.size() > 0) begin
            check("wrap_drain", 32'(rd_data), 32'(q[0]));
            step(1'b0, 8'h00, 1'b1, 1'b0);
            void'(q.pop_front());
        end
        check("wrap_empty", 32'(empty), 32'd1);

        // Reset in the middle of a drain takes effect without a clock edge.
        step(1'b1, 8'hD1, 1'b0, 1'b0);
        step(1'b1, 8'hD2, 1'b0, 1'b0);
        step(1'b1, 8'hD3, 1'b0, 1'b0);
        step(1'b1, 8'hFF, 1'b1, 1'b0);
        check("mid_count", 32'(count),   32'd3);
        check("mid_head",  32'(rd_data), 32'hD2);
        rd_ready = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check("arst_count", 32'(count),    32'd0);
        check("arst_empty", 32'(empty),    32'd1);
        check("arst_valid", 32'(rd_valid), 32'd0);
        check("arst_data",  32'(rd_data),  32'd0);
        check("arst_full",  32'(full),     32'd0);
        check("arst_ovf",   32'(overflow), 32'd0);
        rd_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("arst_rel_empty", 32'(empty), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
